// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
// Module  : piso_pkg
// Purpose : Shared types and constants for the piso_tx serializer.
//           - state_t       : transmitter FSM state encoding {IDLE, SHIFT}
//           - DEFAULT_WIDTH : default parallel word width
// Revision: 1.0 - initial release
// ============================================================================
package piso_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
// Module  : piso_tx
// Purpose : Parallel-in serial-out transmitter, LSB first, feeding a
//           downstream serial-in parallel-out deserializer. Words are taken
//           through a valid/ready handshake; a new word may be accepted in
//           the last bit cycle of the current one, so back-to-back words are
//           sent with no idle bubble.
// Ports   : clk        - rising-edge clock
//           reset      - asynchronous, active-high reset
//           data_in    - parallel word, sampled only on an accept edge
//           data_valid - upstream presents data_in
//           data_ready - a word can be accepted this cycle
//           serial_out - current serial bit (LSB first)
//           bit_valid  - serial_out carries a valid bit this cycle
//           done       - high during the last bit cycle of a word
// Config  : PISO_PARITY_EN - when defined, an even-parity bit (XOR of the
//           accepted word) is sent after the data bits as one extra cycle.
// Revision: 1.0 - initial release
// ============================================================================
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             done
);

`ifdef PISO_PARITY_EN
  // Parity rides as the top bit of the shifter, so it falls out of bit 0
  // right after the data bits without a separate output mux.
  localparam int SH_W  = WIDTH + 1;
`else
  localparam int SH_W  = WIDTH;
`endif
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SH_W - 1);

  state_t            state_q, state_d;
  logic [SH_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  logic              w_last;
  logic              w_accept;
  logic [SH_W-1:0]   w_load_word;

`ifdef PISO_PARITY_EN
  assign w_load_word = {^data_in, data_in};
`else
  assign w_load_word = data_in;
`endif

  // All outputs decode from registers only; data_valid never reaches them.
  assign w_last     = (state_q == SHIFT) && (cnt_q == LAST);
  assign bit_valid  = (state_q == SHIFT);
  assign serial_out = shreg_q[0];
  assign done       = w_last;
  assign data_ready = (state_q == IDLE) || w_last;
  assign w_accept   = data_valid && data_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          state_d = SHIFT;
          shreg_d = w_load_word;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (!w_last) begin
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (w_accept) begin
          // Reload in the last bit cycle: next word's bit 0 follows directly.
          state_d = SHIFT;
          shreg_d = w_load_word;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          shreg_d = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_piso_tx
// Purpose : Self-checking bench for piso_tx: table-driven vectors, directed
//           multi-cycle sequences, and random traffic against a bit-queue
//           reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_piso_tx;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         data_valid = 1'b0;
  logic         data_ready;
  logic         serial_out;
  logic         bit_valid;
  logic         done;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: queue of bits still to appear on serial_out.
  logic        mq[$];
  logic [15:0] obs_v;
  logic [W-1:0] rx;

  typedef struct {
    logic [W-1:0] din;
    logic         dv;
    logic         so;
    logic         bv;
    logic         dn;
    logic         rdy;
  } vec_t;

  vec_t tbl[$];

  piso_tx #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .serial_out(serial_out),
    .bit_valid (bit_valid),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " serial_out"}, 16'(serial_out), 16'd0);
    chk({tag, " bit_valid"},  16'(bit_valid),  16'd0);
    chk({tag, " done"},       16'(done),       16'd0);
    chk({tag, " data_ready"}, 16'(data_ready), 16'd1);
  endtask

  task automatic add(input logic [W-1:0] din, input logic dv,
                     input logic so, input logic bv, input logic dn, input logic rdy);
    vec_t v;
    v.din = din; v.dv = dv; v.so = so; v.bv = bv; v.dn = dn; v.rdy = rdy;
    tbl.push_back(v);
  endtask

  // Called #1 after a rising edge: compare outputs with the model, drive the
  // next inputs, advance one edge and update the model.
  task automatic cyc(input logic dv, input logic [W-1:0] din);
    logic exp_rdy;
    exp_rdy = (mq.size() <= 1);
    chk("model bit_valid",  16'(bit_valid),  16'(mq.size() != 0));
    chk("model serial_out", 16'(serial_out), 16'((mq.size() != 0) ? mq[0] : 1'b0));
    chk("model done",       16'(done),       16'(mq.size() == 1));
    chk("model data_ready", 16'(data_ready), 16'(exp_rdy));
    if (bit_valid) obs_v = {obs_v[14:0], serial_out};
    data_valid = dv;
    data_in    = din;
    @(posedge clk);
    if (mq.size() != 0) void'(mq.pop_front());
    if (dv && exp_rdy) begin
      for (int i = 0; i < W; i++) mq.push_back(din[i]);
`ifdef PISO_PARITY_EN
      mq.push_back(^din);
`endif
    end
    #1;
  endtask

  initial begin
    // ---------------- reset, asserted away from any edge ----------------
    #2;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // ---------------- table-driven single word and back-to-back ---------
`ifndef PISO_PARITY_EN
    // 4'b1011 -> 1,1,0,1
    add(4'hB, 1, 0, 0, 0, 1);
    add(4'h0, 0, 1, 1, 0, 0);
    add(4'h0, 0, 1, 1, 0, 0);
    add(4'h0, 0, 0, 1, 0, 0);
    add(4'h0, 0, 1, 1, 1, 1);
    // 4'hA then 4'h5 held valid -> 0,1,0,1,1,0,1,0
    add(4'hA, 1, 0, 0, 0, 1);
    add(4'h5, 1, 0, 1, 0, 0);
    add(4'h5, 1, 1, 1, 0, 0);
    add(4'h5, 1, 0, 1, 0, 0);
    add(4'h5, 1, 1, 1, 1, 1);
    add(4'h0, 0, 1, 1, 0, 0);
    add(4'h0, 0, 0, 1, 0, 0);
    add(4'h0, 0, 1, 1, 0, 0);
    add(4'h0, 0, 0, 1, 1, 1);
    add(4'h0, 0, 0, 0, 0, 1);
`else
    // 4'b0111 -> 1,1,1,0, parity 1
    add(4'h7, 1, 0, 0, 0, 1);
    add(4'h0, 0, 1, 1, 0, 0);
    add(4'h0, 0, 1, 1, 0, 0);
    add(4'h0, 0, 1, 1, 0, 0);
    add(4'h0, 0, 0, 1, 0, 0);
    add(4'h0, 0, 1, 1, 1, 1);
    // 4'hA then 4'h5 -> 0,1,0,1,p0, 1,0,1,0,p0
    add(4'hA, 1, 0, 0, 0, 1);
    add(4'h5, 1, 0, 1, 0, 0);
    add(4'h5, 1, 1, 1, 0, 0);
    add(4'h5, 1, 0, 1, 0, 0);
    add(4'h5, 1, 1, 1, 0, 0);
    add(4'h5, 1, 0, 1, 1, 1);
    add(4'h0, 0, 1, 1, 0, 0);
    add(4'h0, 0, 0, 1, 0, 0);
    add(4'h0, 0, 1, 1, 0, 0);
    add(4'h0, 0, 0, 1, 0, 0);
    add(4'h0, 0, 0, 1, 1, 1);
    add(4'h0, 0, 0, 0, 0, 1);
`endif
    rx = '0;
    for (int r = 0; r < tbl.size(); r++) begin
      chk($sformatf("tbl[%0d] serial_out", r), 16'(serial_out), 16'(tbl[r].so));
      chk($sformatf("tbl[%0d] bit_valid", r),  16'(bit_valid),  16'(tbl[r].bv));
      chk($sformatf("tbl[%0d] done", r),       16'(done),       16'(tbl[r].dn));
      chk($sformatf("tbl[%0d] data_ready", r), 16'(data_ready), 16'(tbl[r].rdy));
`ifndef PISO_PARITY_EN
      // Deserializer view of the first word (LSB shifted in first).
      if (r >= 1 && r <= 4 && bit_valid) rx = {serial_out, rx[W-1:1]};
      if (r == 4) chk("deserializer word", 16'(rx), 16'hB);
`endif
      data_valid = tbl[r].dv;
      data_in    = tbl[r].din;
      @(posedge clk); #1;
    end
    data_valid = 1'b0;
    mq.delete();

    // ---------------- ignored request during 2nd bit of 4'h3 -----------
    obs_v = '0;
    cyc(1, 4'h3);
    cyc(0, 4'h0);
    cyc(1, 4'hF);
    for (int i = 0; i < 4; i++) cyc(0, 4'h0);
`ifndef PISO_PARITY_EN
    chk("ignored stream", obs_v, 16'b1100);
`else
    chk("ignored stream", obs_v, 16'b11000);
`endif

    // ---------------- abort with reset during 2nd bit of 4'h6 ----------
    cyc(1, 4'h6);
    cyc(0, 4'h0);
    #3;
    reset = 1'b1;
    #1;
    chk_reset_outputs("abort");
    mq.delete();
    @(posedge clk); #1;
    chk_reset_outputs("abort held");
    reset = 1'b0;
    obs_v = '0;
    cyc(1, 4'h9);
    for (int i = 0; i < 6; i++) cyc(0, 4'h0);
`ifndef PISO_PARITY_EN
    chk("post-abort stream", obs_v, 16'b1001);
`else
    chk("post-abort stream", obs_v, 16'b10010);
`endif

    // ---------------- random traffic vs model --------------------------
    for (int i = 0; i < 400; i++) begin
      cyc(logic'($urandom_range(0, 3) != 0), W'($urandom));
    end
    for (int i = 0; i < 8; i++) cyc(0, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
